unary_binary_dot_engine: RTL and testbench

//  Multi-lane temporal-unary/binary MAC computing out = sum_j(a_j*b_j + c_j) over SETS lanes.

---
 rtl/unary_binary_dot_engine.sv | 150 +++++++++++++++
 tb/tb_unary_binary_dot_engine.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/unary_binary_dot_engine.sv
// Multi-lane temporal-unary/binary dot-product engine: out = sum_j(a_j*b_j + c_j).
// a_j and c_j are replayed as pulse trains against a shared counter; b_j is added in binary.
module unary_binary_dot_engine #(
  parameter  int SIZE      = 6,
  parameter  int SETS      = 16,
  parameter  int ACC_EXTRA = 4,
  localparam int OUT_W     = 2*SIZE + $clog2(SETS) + ACC_EXTRA + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_acc,
  input  logic [SETS*SIZE-1:0] a,
  input  logic [SETS*SIZE-1:0] b,
  input  logic [SETS*SIZE-1:0] c,
  input  logic                 abort,
  output logic                 busy,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_W-1:0]     out_data,
  output logic                 out_ovf
);

  localparam int LVLS  = $clog2(SETS);
  localparam int P     = 1 << LVLS;
  localparam int ADD_W = SIZE + LVLS + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state_q, state_d;
  logic [SETS*SIZE-1:0]   a_q, b_q, c_q;
  logic [SIZE-1:0]        max_q;
  logic [SIZE-1:0]        maxIn;
  logic [SIZE:0]          count_q;
  logic [OUT_W-1:0]       acc_q;
  logic                   ovf_q;
  logic [ADD_W-1:0]       laneTerm [P];
  logic [ADD_W-1:0]       addend;
  logic [OUT_W:0]         accSum;
  logic                   lastCycle;

  // Longest pulse train among all incoming a_j and c_j sets the RUN length.
  always_comb begin
    maxIn = '0;
    for (int j = 0; j < SETS; j++) begin
      if (a[j*SIZE +: SIZE] > maxIn) maxIn = a[j*SIZE +: SIZE];
      if (c[j*SIZE +: SIZE] > maxIn) maxIn = c[j*SIZE +: SIZE];
    end
  end

  for (genvar j = 0; j < P; j++) begin : g_lane
    if (j < SETS) begin : g_real
      logic aHit, cHit;
      assign aHit = count_q < {1'b0, a_q[j*SIZE +: SIZE]};
      assign cHit = count_q < {1'b0, c_q[j*SIZE +: SIZE]};
      assign laneTerm[j] = (aHit ? ADD_W'(b_q[j*SIZE +: SIZE]) : ADD_W'(0))
                         + (cHit ? ADD_W'(1) : ADD_W'(0));
    end else begin : g_pad
      assign laneTerm[j] = '0;
    end
  end

  // Pairwise halving keeps the lane reduction a balanced tree of depth log2(P).
  always_comb begin : addTree
    logic [ADD_W-1:0] node [P];
    for (int k = 0; k < P; k++) node[k] = laneTerm[k];
    for (int w = P / 2; w >= 1; w = w / 2) begin
      for (int k = 0; k < w; k++) node[k] = node[2*k] + node[2*k+1];
    end
    addend = node[0];
  end

  assign accSum    = {1'b0, acc_q} + (OUT_W+1)'(addend);
  assign lastCycle = (count_q + (SIZE+1)'(1)) == {1'b0, max_q};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = (maxIn == '0) ? DONE : RUN;
      RUN:     if (abort) state_d = IDLE;
               else if (lastCycle) state_d = DONE;
      DONE:    if (abort || out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE:    in_ready  = 1'b1;
      RUN:     busy      = 1'b1;
      DONE:    out_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

  // Overflow is sticky across accumulate jobs and only cleared by a fresh job or abort.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      max_q   <= '0;
      count_q <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          a_q     <= a;
          b_q     <= b;
          c_q     <= c;
          max_q   <= maxIn;
          count_q <= '0;
          if (!in_acc) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
          end
        end
        RUN: if (abort) begin
          acc_q   <= '0;
          ovf_q   <= 1'b0;
          count_q <= '0;
        end else begin
          acc_q   <= accSum[OUT_W-1:0];
          count_q <= count_q + (SIZE+1)'(1);
          if (accSum[OUT_W]) ovf_q <= 1'b1;
        end
        DONE: if (abort) begin
          acc_q   <= '0;
          ovf_q   <= 1'b0;
          count_q <= '0;
        end
        default: count_q <= '0;
      endcase
    end
  end

  assign out_data = acc_q;
  assign out_ovf  = ovf_q;

endmodule

// File: tb/tb_unary_binary_dot_engine.sv
// Self-checking bench for unary_binary_dot_engine: directed scenarios plus randomized jobs
// scored against an arithmetic dot-product/accumulator model.
module tb_unary_binary_dot_engine;

  localparam int SIZE      = 6;
  localparam int SETS      = 16;
  localparam int ACC_EXTRA = 4;
  localparam int OUT_W     = 2*SIZE + $clog2(SETS) + ACC_EXTRA + 1;
  localparam int S_OUT_W   = 5;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 in_valid, in_acc, abort, out_ready;
  logic                 in_ready, busy, out_valid, out_ovf;
  logic [SETS*SIZE-1:0] a, b, c;
  logic [OUT_W-1:0]     out_data;

  logic                 sInValid, sInAcc, sAbort, sOutReady;
  logic                 sInReady, sBusy, sOutValid, sOutOvf;
  logic [1:0]           sA, sB, sC;
  logic [S_OUT_W-1:0]   sOutData;

  int     checkCount = 0;
  int     passCount  = 0;
  int     opA [SETS];
  int     opB [SETS];
  int     opC [SETS];
  longint modelAcc = 0;
  bit     modelOvf = 0;
  int     expLatency;

  always #5 clk = ~clk;

  unary_binary_dot_engine #(.SIZE(SIZE), .SETS(SETS), .ACC_EXTRA(ACC_EXTRA)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_acc(in_acc),
    .a(a), .b(b), .c(c), .abort(abort), .busy(busy), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf)
  );

  unary_binary_dot_engine #(.SIZE(2), .SETS(1), .ACC_EXTRA(0)) dutSmall (
    .clk(clk), .reset(reset), .in_valid(sInValid), .in_ready(sInReady), .in_acc(sInAcc),
    .a(sA), .b(sB), .c(sC), .abort(sAbort), .busy(sBusy), .out_valid(sOutValid),
    .out_ready(sOutReady), .out_data(sOutData), .out_ovf(sOutOvf)
  );

  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    checkCount++;
    if (observed == expected) passCount++;
    else $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
  endtask

  function automatic longint refDot();
    longint s = 0;
    for (int j = 0; j < SETS; j++) s += longint'(opA[j]) * longint'(opB[j]) + longint'(opC[j]);
    return s;
  endfunction

  function automatic int refMax();
    int m = 0;
    for (int j = 0; j < SETS; j++) begin
      if (opA[j] > m) m = opA[j];
      if (opC[j] > m) m = opC[j];
    end
    return m;
  endfunction

  task automatic setOps(input int va, input int vb, input int vc);
    for (int j = 0; j < SETS; j++) begin
      opA[j] = va;
      opB[j] = vb;
      opC[j] = vc;
    end
  endtask

  task automatic setT1Ops();
    setOps(0, 0, 0);
    opA[0] = 3; opA[1] = 5;
    opB[0] = 2; opB[1] = 7;
    opC[0] = 1; opC[1] = 0;
  endtask

  task automatic clearModel();
    modelAcc = 0;
    modelOvf = 0;
  endtask

  // Offers one job on the accept edge, updates the model, then scrambles the operand bus.
  task automatic applyStimulus(input bit accFlag);
    longint total;
    if (!accFlag) clearModel();
    total = modelAcc + refDot();
    if (total >= (longint'(1) << OUT_W)) modelOvf = 1;
    modelAcc   = total % (longint'(1) << OUT_W);
    expLatency = refMax() + 1;
    checkOutput("ready before offer", longint'(in_ready), 1);
    for (int j = 0; j < SETS; j++) begin
      a[j*SIZE +: SIZE] = SIZE'(opA[j]);
      b[j*SIZE +: SIZE] = SIZE'(opB[j]);
      c[j*SIZE +: SIZE] = SIZE'(opC[j]);
    end
    in_acc   = accFlag;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_acc   = 1'($urandom);
    a = {$urandom(), $urandom(), $urandom()};
    b = {$urandom(), $urandom(), $urandom()};
    c = {$urandom(), $urandom(), $urandom()};
    checkOutput("ready after accept", longint'(in_ready), 0);
  endtask

  task automatic waitResult(input string tag);
    int edges = 1;
    while (out_valid !== 1'b1 && edges < 80) begin
      @(posedge clk); #1;
      edges++;
    end
    checkOutput({tag, " latency"}, edges, expLatency);
    checkOutput({tag, " data"}, longint'(out_data), modelAcc);
    checkOutput({tag, " ovf"}, longint'(out_ovf), longint'(modelOvf));
  endtask

  task automatic releaseResult(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput({tag, " idle ready"}, longint'(in_ready), 1);
    checkOutput({tag, " valid dropped"}, longint'(out_valid), 0);
  endtask

  task automatic collectResult(input string tag, input int holdCycles);
    waitResult(tag);
    if (holdCycles > 0) begin
      repeat (holdCycles) @(posedge clk);
      #1;
      checkOutput({tag, " held data"}, longint'(out_data), modelAcc);
      checkOutput({tag, " held valid"}, longint'(out_valid), 1);
      checkOutput({tag, " held not ready"}, longint'(in_ready), 0);
    end
    releaseResult(tag);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " in_ready"}, longint'(in_ready), 1);
    checkOutput({tag, " busy"}, longint'(busy), 0);
    checkOutput({tag, " out_valid"}, longint'(out_valid), 0);
    checkOutput({tag, " out_data"}, longint'(out_data), 0);
    checkOutput({tag, " out_ovf"}, longint'(out_ovf), 0);
  endtask

  task automatic pulseReset(input string tag);
    #2 reset = 1'b1;
    #1 checkResetState(tag);
    clearModel();
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
  endtask

  // Small-configuration job: a=b=c=3 in one 2-bit lane, result width 5.
  task automatic smallJob(input bit accFlag, input int expData, input int expOvf);
    int edges = 1;
    sInAcc   = accFlag;
    sInValid = 1'b1;
    @(posedge clk); #1;
    sInValid = 1'b0;
    while (sOutValid !== 1'b1 && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
    checkOutput("small latency", edges, 4);
    checkOutput("small data", longint'(sOutData), expData);
    checkOutput("small ovf", longint'(sOutOvf), expOvf);
    sOutReady = 1'b1;
    @(posedge clk); #1;
    sOutReady = 1'b0;
  endtask

  initial begin
    int sawValid;
    reset = 1'b1;
    in_valid = 0; in_acc = 0; abort = 0; out_ready = 0;
    a = '0; b = '0; c = '0;
    sInValid = 0; sInAcc = 0; sAbort = 0; sOutReady = 0;
    sA = 2'd3; sB = 2'd3; sC = 2'd3;
    #12 checkResetState("reset");
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    $display("[TB] basic job and accumulate chain");
    setT1Ops();
    applyStimulus(0);
    collectResult("T1", 0);
    checkOutput("T1 value", longint'(modelAcc), 42);
    applyStimulus(1);
    collectResult("T3 acc", 0);
    applyStimulus(0);
    collectResult("T3 fresh", 0);

    $display("[TB] zero job and long hold");
    setOps(0, 0, 0);
    applyStimulus(0);
    collectResult("T2", 10);

    $display("[TB] job offered together with out_ready");
    setT1Ops();
    applyStimulus(0);
    waitResult("overlap");
    out_ready = 1'b1;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    checkOutput("overlap not accepted busy", longint'(busy), 0);
    checkOutput("overlap idle", longint'(in_ready), 1);
    out_ready = 1'b0;
    in_valid  = 1'b0;

    $display("[TB] small configuration wrap");
    smallJob(0, 12, 0);
    smallJob(1, 24, 0);
    smallJob(1, 4, 1);

    $display("[TB] full-scale job and abort");
    setOps(63, 63, 63);
    applyStimulus(0);
    collectResult("T5", 2);
    applyStimulus(0);
    repeat (19) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    clearModel();
    checkResetState("abort run");
    sawValid = 0;
    repeat (70) begin
      @(posedge clk); #1;
      if (out_valid) sawValid++;
    end
    checkOutput("abort no result", sawValid, 0);

    setT1Ops();
    abort = 1'b1;
    applyStimulus(0);
    abort = 1'b0;
    collectResult("abort idle accepted", 0);
    applyStimulus(0);
    waitResult("abort done");
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    clearModel();
    checkResetState("abort done");

    $display("[TB] sticky overflow");
    setOps(63, 63, 63);
    applyStimulus(0);
    collectResult("ovf start", 0);
    for (int i = 0; i < 33; i++) begin
      applyStimulus(1);
      waitResult("ovf chain");
      releaseResult("ovf chain");
    end
    checkOutput("ovf sticky model", longint'(modelOvf), 1);
    applyStimulus(0);
    collectResult("ovf cleared", 0);

    $display("[TB] randomized jobs");
    for (int n = 0; n < 25; n++) begin
      for (int j = 0; j < SETS; j++) begin
        opA[j] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 63));
        opB[j] = int'($urandom_range(0, 63));
        opC[j] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 63));
      end
      if (n % 7 == 6) setOps(0, int'($urandom_range(0, 63)), 0);
      applyStimulus(n == 0 ? 1'b0 : 1'($urandom));
      collectResult("random", int'($urandom_range(0, 3)));
    end

    $display("[TB] reset during RUN and DONE");
    setT1Ops();
    applyStimulus(1);
    @(posedge clk); #1;
    pulseReset("reset in run");
    applyStimulus(1);
    waitResult("pre-reset done");
    pulseReset("reset in done");
    applyStimulus(1);
    collectResult("after reset", 0);
    checkOutput("after reset value", longint'(out_data), 42);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
